// File: rtl/popcount_pkg.sv
// popcount_pkg
//   Shared definitions for the popcount scheduler: FSM state encoding,
//   default sizing constants and the result-width helper.
package popcount_pkg;

  localparam int DEF_N_REQ  = 4;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bits needed to hold a count of 0..data_w inclusive.
  function automatic int cnt_width(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/popcount_shifter.sv
// popcount_shifter
//   Shift-based bit counter. A word is loaded into shift register A and the
//   count is cleared; each enabled cycle adds A[0] to the count and shifts A
//   right by one. Once A is empty no further work is done, which gives the
//   early termination on the highest set bit.
//
// Ports
//   clk    in   clock
//   reset  in   synchronous, active-high reset
//   load   in   load din into A and clear count (wins over en)
//   din    in   DATA_W word to count
//   en     in   advance one bit
//   count  out  running number of set bits seen
//   zero   out  A holds no set bits
module popcount_shifter
  import popcount_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = cnt_width(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  input  logic              en,
  output logic [CNT_W-1:0]  count,
  output logic              zero
);

  logic [DATA_W-1:0] a_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q   <= '0;
      count <= '0;
    end else if (load) begin
      a_q   <= din;
      count <= '0;
    end else if (en && (a_q != '0)) begin
      count <= count + CNT_W'(a_q[0]);
      a_q   <= a_q >> 1;
    end
  end

  assign zero = (a_q == '0);

endmodule

// File: rtl/popcount_scheduler.sv
// popcount_scheduler
//   Shares one popcount_shifter between N_REQ requesters. A round-robin
//   arbiter picks a pending requester in IDLE, the word is counted in COUNT,
//   and DONE pulses a one-hot ack together with the registered result.
//
// Ports
//   clk        in   clock
//   reset      in   synchronous, active-high reset
//   req        in   N_REQ request levels, held with data until ack
//   data       in   N_REQ*DATA_W flattened words, requester i at [i*DATA_W +: DATA_W]
//   ack        out  one-hot, one-cycle pulse to the served requester
//   result     out  popcount of the last served word, held until next DONE
//   result_id  out  index of the last served requester, held with result
//   busy       out  high in COUNT and DONE
//
// state | meaning
// IDLE  | waiting for any req; arbitrate and load the winner's word
// COUNT | shifting the word, one bit per cycle until it is empty
// DONE  | single cycle: ack, result and result_id are presented
module popcount_scheduler
  import popcount_pkg::*;
#(
  parameter int N_REQ  = DEF_N_REQ,
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = cnt_width(DATA_W),
  parameter int IDX_W  = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] data,
  output logic [N_REQ-1:0]        ack,
  output logic [CNT_W-1:0]        result,
  output logic [IDX_W-1:0]        result_id,
  output logic                    busy
);

  state_t state, next_state;

  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  cur_id;
  logic [IDX_W-1:0]  grant_idx;
  logic              grant_found;
  logic [DATA_W-1:0] grant_word;

  logic              sh_load;
  logic              sh_en;
  logic [CNT_W-1:0]  sh_count;
  logic              sh_zero;

  logic [N_REQ-1:0]  ack_nxt;
  logic [CNT_W-1:0]  result_nxt;
  logic [IDX_W-1:0]  result_id_nxt;
  logic              busy_nxt;

  // (base + off) mod N_REQ for base, off < N_REQ. One conditional subtract
  // is enough and keeps non-power-of-two N_REQ wrapping correctly.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                input int unsigned      off);
    logic [IDX_W:0] sum;
    sum = {1'b0, base} + (IDX_W+1)'(off);
    if (sum >= (IDX_W+1)'(N_REQ)) begin
      sum = sum - (IDX_W+1)'(N_REQ);
    end
    return sum[IDX_W-1:0];
  endfunction

  // Round-robin scan starting at rr_ptr; the first pending requester wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!grant_found && req[wrap_add(rr_ptr, i)]) begin
        grant_found = 1'b1;
        grant_idx   = wrap_add(rr_ptr, i);
      end
    end
  end

  assign grant_word = data[int'(grant_idx)*DATA_W +: DATA_W];

  assign sh_load = (state == IDLE) && grant_found;
  assign sh_en   = (state == COUNT);

  popcount_shifter #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_shifter (
    .clk   (clk),
    .reset (reset),
    .load  (sh_load),
    .din   (grant_word),
    .en    (sh_en),
    .count (sh_count),
    .zero  (sh_zero)
  );

  // State register, plus the job bookkeeping that moves with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cur_id <= '0;
      rr_ptr <= '0;
    end else begin
      state <= next_state;
      if (sh_load) begin
        cur_id <= grant_idx;
      end
      if (state == DONE) begin
        rr_ptr <= wrap_add(cur_id, 1);
      end
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (grant_found) next_state = COUNT;
      COUNT:   if (sh_zero)     next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode. Outputs are computed from next_state so that the
  // registered versions line up with the state they belong to; result is
  // captured on the COUNT->DONE edge, when the count is final.
  always_comb begin
    ack_nxt       = '0;
    result_nxt    = result;
    result_id_nxt = result_id;
    busy_nxt      = (next_state != IDLE);
    if (next_state == DONE) begin
      ack_nxt       = N_REQ'(1) << cur_id;
      result_nxt    = sh_count;
      result_id_nxt = cur_id;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ack       <= '0;
      result    <= '0;
      result_id <= '0;
      busy      <= 1'b0;
    end else begin
      ack       <= ack_nxt;
      result    <= result_nxt;
      result_id <= result_id_nxt;
      busy      <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_popcount_scheduler.sv
module tb_popcount_scheduler;

  localparam int N_REQ  = 4;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;
  localparam int IDX_W  = 2;

  logic                    clk;
  logic                    reset;
  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] data;
  logic [N_REQ-1:0]        ack;
  logic [CNT_W-1:0]        result;
  logic [IDX_W-1:0]        result_id;
  logic                    busy;

  popcount_scheduler #(
    .N_REQ  (N_REQ),
    .DATA_W (DATA_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .data      (data),
    .ack       (ack),
    .result    (result),
    .result_id (result_id),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int id;
    int res;
    int cyc;
  } job_t;

  job_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_word(input int i, input logic [DATA_W-1:0] w);
    data[i*DATA_W +: DATA_W] = w;
  endtask

  // Reference model: popcount and COUNT duration (highest set bit + 2,
  // or 1 for an all-zero word).
  task automatic expect_job(input int id, input logic [DATA_W-1:0] w);
    job_t j;
    int   hi;
    j.id  = id;
    j.res = 0;
    hi    = -1;
    for (int b = 0; b < DATA_W; b++) begin
      if (w[b]) begin
        j.res++;
        hi = b;
      end
    end
    j.cyc = (hi < 0) ? 1 : hi + 2;
    sb.push_back(j);
  endtask

  // Wait for the next ack, counting COUNT cycles (busy without ack) since
  // the previous ack, and compare against the head of the scoreboard.
  // Requesters not in hold drop req once acked.
  task automatic serve_one(input logic [N_REQ-1:0] hold);
    int   n;
    bit   got;
    job_t e;
    n   = 0;
    got = 1'b0;
    for (int t = 0; t < 40 && !got; t++) begin
      tick();
      if (ack != '0) got = 1'b1;
      else if (busy) n++;
    end
    chk("ack_timeout", int'(got), 1);
    if (got) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", int'(ack), 0);
      end else begin
        e = sb.pop_front();
        chk("count_cycles", n, e.cyc);
        chk("ack_onehot", int'(ack), 1 << e.id);
        chk("result", int'(result), e.res);
        chk("result_id", int'(result_id), e.id);
        chk("busy_in_done", int'(busy), 1);
      end
      req = req & ~(ack & ~hold);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int acks_seen;
    reset = 1'b1;
    req   = '0;
    data  = '0;
    do_reset();

    chk("rst_ack", int'(ack), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_result_id", int'(result_id), 0);

    // Single job, two set bits, highest at bit 5.
    set_word(0, 8'b0010_0100);
    req = 4'b0001;
    expect_job(0, 8'b0010_0100);
    tick();
    chk("busy_next_cycle", int'(busy), 1);
    chk("no_early_ack", int'(ack), 0);
    begin
      int   n;
      bit   got;
      job_t e;
      n   = 1;
      got = 1'b0;
      for (int t = 0; t < 40 && !got; t++) begin
        tick();
        if (ack != '0) got = 1'b1;
        else if (busy) n++;
      end
      chk("t1_timeout", int'(got), 1);
      e = sb.pop_front();
      chk("t1_count_cycles", n, e.cyc);
      chk("t1_ack", int'(ack), 1 << e.id);
      chk("t1_result", int'(result), e.res);
      chk("t1_result_id", int'(result_id), e.id);
      req = '0;
      tick();
      chk("t1_ack_one_cycle", int'(ack), 0);
      chk("t1_idle_busy", int'(busy), 0);
      chk("t1_result_held", int'(result), 2);
    end

    // Zero word: one COUNT cycle.
    set_word(1, 8'h00);
    req = 4'b0010;
    expect_job(1, 8'h00);
    serve_one('0);

    // Full word: maximum count, no overflow.
    set_word(1, 8'hFF);
    req = 4'b0010;
    expect_job(1, 8'hFF);
    serve_one('0);

    // Four simultaneous requesters from rr_ptr=0, then requester 0 returns.
    do_reset();
    set_word(0, 8'h01);
    set_word(1, 8'h03);
    set_word(2, 8'h07);
    set_word(3, 8'h0F);
    req = 4'b1111;
    expect_job(0, 8'h01);
    expect_job(1, 8'h03);
    expect_job(2, 8'h07);
    expect_job(3, 8'h0F);
    serve_one('0);
    serve_one('0);
    req[0] = 1'b1;
    expect_job(0, 8'h01);
    serve_one('0);
    serve_one('0);
    serve_one('0);
    chk("rr_all_dropped", int'(req), 0);

    // Two requesters holding req continuously alternate.
    do_reset();
    set_word(0, 8'h01);
    set_word(2, 8'h03);
    req = 4'b0101;
    expect_job(0, 8'h01);
    expect_job(2, 8'h03);
    expect_job(0, 8'h01);
    expect_job(2, 8'h03);
    for (int k = 0; k < 4; k++) serve_one(4'b0101);
    req = '0;
    tick();
    tick();
    chk("hold_idle", int'(busy), 0);

    // Reset in the middle of COUNT drops the job.
    set_word(0, 8'hFF);
    req = 4'b0001;
    tick();
    tick();
    tick();
    chk("mid_busy", int'(busy), 1);
    chk("mid_result_held", int'(result), 2);
    chk("mid_result_id_held", int'(result_id), 2);
    reset = 1'b1;
    req   = '0;
    tick();
    chk("abort_busy", int'(busy), 0);
    chk("abort_ack", int'(ack), 0);
    chk("abort_result", int'(result), 0);
    chk("abort_result_id", int'(result_id), 0);
    reset = 1'b0;
    acks_seen = 0;
    for (int t = 0; t < 15; t++) begin
      tick();
      if (ack != '0) acks_seen++;
    end
    chk("abort_no_ack", acks_seen, 0);
    chk("abort_stays_idle", int'(busy), 0);
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
